// File: rtl/tc_div_if.sv
// ============================================================================
// Module   : tc_div_if
// Brief    : Start/done handshake and operand/result bundle for tc_div.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tc_div_if #(
  parameter int W = 8
);
  logic             start;
  logic [2*W-1:0]   a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   q;
  logic [W-1:0]     r;
  logic             done;
  logic             busy;
  logic             dz;
  logic             ovf;

  modport master (
    output start, a, b,
    input  q, r, done, busy, dz, ovf
  );

  modport slave (
    input  start, a, b,
    output q, r, done, busy, dz, ovf
  );
endinterface

`default_nettype wire

// File: rtl/tc_div.sv
// ============================================================================
// Module   : tc_div
// Brief    : Sequential signed 2W/W restoring divider, one quotient bit per
//            clock plus a sign fix-up. Define TC_DIV_DZ_FAST_EN to skip the
//            iterations on divide-by-zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tc_div #(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  tc_div_if.slave  bus
);

  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  logic [W2-1:0]   r_dvd;     // dividend magnitude, becomes quotient magnitude
  logic [W-1:0]    r_bmag;
  logic [W:0]      r_rem;
  logic [CW-1:0]   r_cnt;
  logic            r_sa;
  logic            r_sq;
  logic            r_bz;
  logic            r_ovfc;

  logic [W2-1:0]   r_q;
  logic [W-1:0]    r_r;
  logic            r_done;
  logic            r_busy;
  logic            r_dzf;
  logic            r_ovf;

  logic [W2-1:0]   w_amag;
  logic [W-1:0]    w_bmag;
  logic            w_bz;
  logic            w_ovfc;
  logic [W+1:0]    w_shift;
  logic            w_ge;
  logic [W2-1:0]   w_qfix;
  logic [W-1:0]    w_rfix;

  // |a| in 2W unsigned bits keeps the most negative dividend exact
  assign w_amag  = bus.a[W2-1] ? W2'(-bus.a) : bus.a;
  assign w_bmag  = bus.b[W-1]  ? W'(-bus.b)  : bus.b;
  assign w_bz    = (bus.b == '0);
  assign w_ovfc  = (bus.a == {1'b1, {(W2-1){1'b0}}}) && (&bus.b);

  assign w_shift = {r_rem, r_dvd[W2-1]};
  assign w_ge    = (w_shift >= {2'b00, r_bmag});

  assign w_qfix  = r_sq ? W2'(-r_dvd) : r_dvd;
  assign w_rfix  = r_sa ? W'(-r_rem[W-1:0]) : r_rem[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_bmag  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_sa    <= 1'b0;
      r_sq    <= 1'b0;
      r_bz    <= 1'b0;
      r_ovfc  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_dzf   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd  <= w_amag;
            r_bmag <= w_bmag;
            r_rem  <= '0;
            r_cnt  <= CW'(W2 - 1);
            r_sa   <= bus.a[W2-1];
            r_sq   <= bus.a[W2-1] ^ bus.b[W-1];
            r_bz   <= w_bz;
            r_ovfc <= w_ovfc;
            r_busy <= 1'b1;
`ifdef TC_DIV_DZ_FAST_EN
            r_state <= w_bz ? S_FIX : S_CALC;
`else
            r_state <= S_CALC;
`endif
          end
        end

        S_CALC: begin
          if (w_ge) begin
            r_rem <= (W+1)'(w_shift - {2'b00, r_bmag});
            r_dvd <= {r_dvd[W2-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[W:0];
            r_dvd <= {r_dvd[W2-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_bz) begin
            r_q <= '0;
            r_r <= '0;
          end else begin
            r_q <= w_qfix;
            r_r <= w_rfix;
          end
          r_dzf   <= r_bz;
          r_ovf   <= r_ovfc & ~r_bz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.done = r_done;
  assign bus.busy = r_busy;
  assign bus.dz   = r_dzf;
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_tc_div.sv
// ============================================================================
// Module   : tb_tc_div
// Brief    : Scoreboard bench for tc_div (honours TC_DIV_DZ_FAST_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tc_div;

  localparam int W     = 8;
  localparam int LAT   = 2 * W + 1;
`ifdef TC_DIV_DZ_FAST_EN
  localparam int DZLAT = 1;
`else
  localparam int DZLAT = 2 * W + 1;
`endif

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tc_div_if #(.W(W)) dif ();
  tc_div #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic res_t model(input logic signed [15:0] a, input logic signed [7:0] b);
    res_t   e;
    longint la, lb;
    la = a;
    lb = b;
    if (lb == 0)                       e = '{16'h0000, 8'h00, 1'b1, 1'b0};
    else if (la == -32768 && lb == -1) e = '{16'h8000, 8'h00, 1'b0, 1'b1};
    else begin
      e.q   = 16'(la / lb);
      e.r   = 8'(la % lb);
      e.dz  = 1'b0;
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Called at #1 after an edge; start is sampled on the next edge.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = 0;
    while (dif.done !== 1'b1 && lat < 60) begin
      if (dif.busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic res_t observed();
    return '{dif.q, dif.r, dif.dz, dif.ovf};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; dif.start = 1'b0; dif.a = '0; dif.b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({dif.q, dif.r, dif.done, dif.busy, dif.dz, dif.ovf} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got q=%h r=%h done=%b busy=%b dz=%b ovf=%b, want all 0",
               dif.q, dif.r, dif.done, dif.busy, dif.dz, dif.ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    res_t e, g;
    launch(16'd100, 8'd7);
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e) begin n_err++; $display("FAIL basic_result: got %h want %h", g, e); end
    n_vec++;
    if (lat !== LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    n_vec++;
    if (bc !== LAT) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, LAT); end
    @(posedge clk); #1;
    n_vec++;
    if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin
      n_err++; $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", dif.done, dif.busy);
    end
  endtask

  task automatic test_signs();
    logic [15:0] ta [5] = '{16'hFF9C, 16'd30, 16'hFFE2, 16'd1000, 16'h8000};
    logic [7:0]  tb [5] = '{8'd7,     8'hF1, 8'hFE,    8'h80,    8'd2};
    int lat, bc;
    res_t e, g;
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb[i]);
      wait_done(lat, bc);
      e = sb.pop_front(); g = observed();
      n_vec++;
      if (g !== e || lat !== LAT) begin
        n_err++;
        $display("FAIL signs_%0d: got %h lat %0d want %h lat %0d", i, g, lat, e, LAT);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    res_t e, g;
    launch(16'd1234, 8'd0);
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e) begin n_err++; $display("FAIL dz_result: got %h want %h", g, e); end
    n_vec++;
    if (lat !== DZLAT) begin n_err++; $display("FAIL dz_latency: got %0d want %0d", lat, DZLAT); end
    launch(16'd9, 8'd2);
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e) begin n_err++; $display("FAIL dz_clear: got %h want %h", g, e); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    res_t e, g;
    launch(16'h8000, 8'hFF);
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e || lat !== LAT) begin
      n_err++; $display("FAIL ovf_result: got %h lat %0d want %h lat %0d", g, lat, e, LAT);
    end
    launch(16'd9, 8'd2);
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e) begin n_err++; $display("FAIL ovf_clear: got %h want %h", g, e); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    res_t e, g;
    launch(16'd100, 8'd7);
    repeat (3) begin @(posedge clk); #1; end
    dif.start = 1'b1; dif.a = 16'd5; dif.b = 8'd1;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.a = '0; dif.b = '0;
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e || lat + 4 !== LAT) begin
      n_err++; $display("FAIL busy_ignore: got %h lat %0d want %h lat %0d", g, lat + 4, e, LAT);
    end
    // start held high during the done cycle
    dif.start = 1'b1; dif.a = 16'd50; dif.b = 8'd5;
    sb.push_back(model(16'd50, 8'd5));
    @(posedge clk); #1;
    dif.start = 1'b0;
    n_vec++;
    if (dif.done !== 1'b0 || dif.busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", dif.done, dif.busy);
    end
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e || lat !== LAT) begin
      n_err++; $display("FAIL b2b_result: got %h lat %0d want %h lat %0d", g, lat, e, LAT);
    end
  endtask

  task automatic test_reset_midop();
    int   lat, bc;
    res_t e, g;
    logic seen_done;
    dif.start = 1'b1; dif.a = 16'd100; dif.b = 8'd7;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({dif.q, dif.r, dif.done, dif.busy, dif.dz, dif.ovf} !== 28'h0) begin
      n_err++;
      $display("FAIL async_reset: got q=%h r=%h done=%b busy=%b dz=%b ovf=%b, want all 0",
               dif.q, dif.r, dif.done, dif.busy, dif.dz, dif.ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (dif.done === 1'b1) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done !== 1'b0) begin n_err++; $display("FAIL aborted_done: got 1 want 0"); end
    launch(16'hFFF9, 8'd3);
    wait_done(lat, bc);
    e = sb.pop_front(); g = observed();
    n_vec++;
    if (g !== e || lat !== LAT) begin
      n_err++; $display("FAIL post_reset_op: got %h lat %0d want %h lat %0d", g, lat, e, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_midop();
    n_vec++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
